// File: rtl/sc_mvm_acc.sv
// Stochastic-computing matrix-vector accumulator: DIM lanes add +/-1 per RUN cycle.
// Define SMVM_SATURATE_EN to saturate the lane accumulators instead of wrapping.
module sc_mvm_acc #(
    parameter int DIM     = 256,
    parameter int NUM_BIT = 8,
    parameter int ACC_W   = NUM_BIT + 8
) (
    input  logic                     i_clk_smvm,
    input  logic                     i_rst_n_smvm,
    input  logic                     i_start_smvm,
    input  logic                     i_clear_smvm,
    input  logic                     i_sign_smvm,
    input  logic [NUM_BIT-1:0]       i_w_smvm,
    input  logic [DIM*NUM_BIT-1:0]   i_x_smvm,
    output logic                     o_busy_smvm,
    output logic                     o_done_smvm,
    output logic [DIM*ACC_W-1:0]     o_acc_smvm,
    output logic [DIM-1:0]           o_sat_smvm
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic signed [ACC_W-1:0] ONE = 1;

`ifdef SMVM_SATURATE_EN
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    function automatic logic hits_rail(input logic signed [ACC_W-1:0] a, input logic inc);
        return (inc && a == ACC_MAX) || (!inc && a == ACC_MIN);
    endfunction
`endif

    function automatic logic signed [ACC_W-1:0] acc_step(input logic signed [ACC_W-1:0] a,
                                                         input logic inc);
`ifdef SMVM_SATURATE_EN
        if (hits_rail(a, inc)) return a;
`endif
        return inc ? a + ONE : a - ONE;
    endfunction

    state_t                   state_q, state_d;
    logic [NUM_BIT-1:0]       w_q, t_q, r_t;
    logic                     sign_q;
    logic                     start_ok, clear_ok, last_run;
    logic [DIM-1:0]           inc;
    logic signed [ACC_W-1:0]  acc_q [DIM];

    assign start_ok = (state_q == IDLE) && i_start_smvm;
    assign clear_ok = start_ok && i_clear_smvm;
    assign last_run = (t_q == w_q - 1'b1);

    always_ff @(posedge i_clk_smvm or negedge i_rst_n_smvm) begin
        if (!i_rst_n_smvm) state_q <= IDLE;
        else               state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start_ok) state_d = (i_w_smvm == '0) ? DONE : RUN;
            RUN:  if (last_run) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign o_busy_smvm = (state_q != IDLE);
    assign o_done_smvm = (state_q == DONE);

    always_ff @(posedge i_clk_smvm or negedge i_rst_n_smvm) begin
        if (!i_rst_n_smvm) begin
            w_q    <= '0;
            sign_q <= 1'b0;
            t_q    <= '0;
        end else if (start_ok) begin
            w_q    <= i_w_smvm;
            sign_q <= i_sign_smvm;
            t_q    <= '0;
        end else if (state_q == RUN) begin
            t_q    <= t_q + 1'b1;
        end
    end

    // Comparison threshold is the bit-reversed phase; each lane steps up when x beats it.
    always_comb begin
        r_t = '0;
        for (int b = 0; b < NUM_BIT; b++) r_t[b] = t_q[NUM_BIT-1-b];
        inc = '0;
        for (int i = 0; i < DIM; i++)
            inc[i] = (i_x_smvm[i*NUM_BIT +: NUM_BIT] > r_t) ^ sign_q;
    end

    always_ff @(posedge i_clk_smvm or negedge i_rst_n_smvm) begin
        if (!i_rst_n_smvm) begin
            for (int i = 0; i < DIM; i++) acc_q[i] <= '0;
        end else if (clear_ok) begin
            for (int i = 0; i < DIM; i++) acc_q[i] <= '0;
        end else if (state_q == RUN) begin
            for (int i = 0; i < DIM; i++) acc_q[i] <= acc_step(acc_q[i], inc[i]);
        end
    end

`ifdef SMVM_SATURATE_EN
    logic [DIM-1:0] sat_q;

    always_ff @(posedge i_clk_smvm or negedge i_rst_n_smvm) begin
        if (!i_rst_n_smvm) begin
            sat_q <= '0;
        end else if (clear_ok) begin
            sat_q <= '0;
        end else if (state_q == RUN) begin
            for (int i = 0; i < DIM; i++)
                if (hits_rail(acc_q[i], inc[i])) sat_q[i] <= 1'b1;
        end
    end

    assign o_sat_smvm = sat_q;
`else
    assign o_sat_smvm = '0;
`endif

    for (genvar g = 0; g < DIM; g++) begin : g_out
        assign o_acc_smvm[g*ACC_W +: ACC_W] = acc_q[g];
    end

endmodule

// File: tb/tb_sc_mvm_acc.sv
// Directed bench for sc_mvm_acc (DIM=4, NUM_BIT=8, ACC_W=16); honours SMVM_SATURATE_EN.
module tb_sc_mvm_acc;

    localparam int DIM = 4;
    localparam int NB  = 8;
    localparam int AW  = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              start = 1'b0;
    logic              clear = 1'b0;
    logic              sign = 1'b0;
    logic [NB-1:0]     w = '0;
    logic [DIM*NB-1:0] x = '0;
    logic              busy, done;
    logic [DIM*AW-1:0] acc;
    logic [DIM-1:0]    sat;

    int n_tests = 0;
    int n_fail  = 0;
    int lat, bc;
    logic done_seen;

    sc_mvm_acc #(.DIM(DIM), .NUM_BIT(NB), .ACC_W(AW)) dut (
        .i_clk_smvm   (clk),
        .i_rst_n_smvm (rst_n),
        .i_start_smvm (start),
        .i_clear_smvm (clear),
        .i_sign_smvm  (sign),
        .i_w_smvm     (w),
        .i_x_smvm     (x),
        .o_busy_smvm  (busy),
        .o_done_smvm  (done),
        .o_acc_smvm   (acc),
        .o_sat_smvm   (sat)
    );

    always #5 clk = ~clk;

    function automatic logic signed [AW-1:0] lane(input int i);
        return acc[i*AW +: AW];
    endfunction

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_lanes(input string tag, input logic signed [63:0] exp);
        for (int i = 0; i < DIM; i++) chk($sformatf("%s[%0d]", tag, i), lane(i), exp);
    endtask

    // One start; lat counts edges after acceptance until done is seen, bcnt counts busy cycles.
    task automatic run(input logic [DIM*NB-1:0] xv, input logic [NB-1:0] wv, input logic sv,
                       input logic cv, input bit poke, output int latv, output int bcnt);
        @(negedge clk);
        x = xv; w = wv; sign = sv; clear = cv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; clear = 1'b0;
        latv = 0; bcnt = 0;
        while (!done && latv < 400) begin
            if (busy) bcnt++;
            if (poke && latv == 2) begin
                start = 1'b1; clear = 1'b1; w = '0;
            end else begin
                start = 1'b0; clear = 1'b0;
            end
            @(posedge clk); #1;
            latv++;
        end
        if (busy) bcnt++;
        start = 1'b0; clear = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        // Asynchronous reset, checked before any clock edge.
        #1 rst_n = 1'b0;
        #3;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sat", sat, 0);
        chk_lanes("rst_acc", 0);
        @(negedge clk) rst_n = 1'b1;

        // All-ones activations, positive weight.
        run({DIM{8'd255}}, 8'd10, 1'b0, 1'b1, 1'b0, lat, bc);
        chk("lat_w10", lat, 10);
        chk("busy_w10", bc, 11);
        chk_lanes("x255_w10", 10);
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);

        run({DIM{8'd0}}, 8'd10, 1'b0, 1'b1, 1'b0, lat, bc);
        chk_lanes("x0_pos", -10);
        run({DIM{8'd0}}, 8'd10, 1'b1, 1'b1, 1'b0, lat, bc);
        chk_lanes("x0_neg", 10);

        run({DIM{8'd128}}, 8'd4, 1'b0, 1'b1, 1'b0, lat, bc);
        chk_lanes("x128_w4", 0);
        run({DIM{8'd128}}, 8'd3, 1'b0, 1'b1, 1'b0, lat, bc);
        chk_lanes("x128_w3", 1);

        // Distinct lanes: x = {64, 255, 128, 0} from lane 3 down to lane 0.
        run({8'd64, 8'd255, 8'd128, 8'd0}, 8'd4, 1'b0, 1'b1, 1'b0, lat, bc);
        chk("mix_l0", lane(0), -4);
        chk("mix_l1", lane(1), 0);
        chk("mix_l2", lane(2), 4);
        chk("mix_l3", lane(3), -2);

        // Accumulate across runs; second run has start+clear poked mid-run.
        run({DIM{8'd255}}, 8'd5, 1'b1, 1'b1, 1'b0, lat, bc);
        chk_lanes("acc_w5", -5);
        run({DIM{8'd255}}, 8'd7, 1'b1, 1'b0, 1'b1, lat, bc);
        chk("lat_w7", lat, 7);
        chk_lanes("acc_w12", -12);
        run({DIM{8'd255}}, 8'd0, 1'b1, 1'b0, 1'b0, lat, bc);
        chk("lat_w0", lat, 0);
        chk("busy_w0", bc, 1);
        chk_lanes("acc_w0", -12);

        // Reset during the third RUN cycle.
        @(negedge clk);
        x = {DIM{8'd255}}; w = 8'd10; sign = 1'b0; clear = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; clear = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk_lanes("mid_rst_acc", 0);
        @(negedge clk) rst_n = 1'b1;
        done_seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            done_seen = done_seen | done | busy;
        end
        chk("mid_rst_nodone", done_seen, 0);
        run({DIM{8'd255}}, 8'd4, 1'b0, 1'b0, 1'b0, lat, bc);
        chk("post_rst_lat", lat, 4);
        chk_lanes("post_rst_acc", 4);

        // Preload to the positive rail: 128*255 + 127 = 32767.
        for (int j = 0; j < 128; j++)
            run({DIM{8'd255}}, 8'd255, 1'b0, (j == 0), 1'b0, lat, bc);
        run({DIM{8'd255}}, 8'd127, 1'b0, 1'b0, 1'b0, lat, bc);
        chk_lanes("preload", 32767);
        chk("preload_sat", sat, 0);
        run({DIM{8'd255}}, 8'd1, 1'b0, 1'b0, 1'b0, lat, bc);
`ifdef SMVM_SATURATE_EN
        chk_lanes("rail_hold", 32767);
        chk("rail_sat", sat, 4'hF);
`else
        chk_lanes("rail_wrap", -32768);
        chk("rail_sat", sat, 0);
`endif
        run({DIM{8'd255}}, 8'd1, 1'b0, 1'b1, 1'b0, lat, bc);
        chk_lanes("clr_acc", 1);
        chk("clr_sat", sat, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sc_mvm_acc.md
SC_MVM_ACC -- requirements
Module: sc_mvm_acc

Interface
REQ-001 Parameter DIM, default 256, number of parallel lanes (1..1024).
REQ-002 Parameter NUM_BIT, default 8, activation and weight magnitude width (4..16).
REQ-003 Parameter ACC_W, default NUM_BIT+8, signed accumulator width (>= NUM_BIT+2).
REQ-004 i_clk_smvm  in  1  sole clock; all state changes on its rising edge.
REQ-005 i_rst_n_smvm  in  1  reset, asynchronous assert, active-low.
REQ-006 i_start_smvm  in  1  start request, sampled only in IDLE.
REQ-007 i_clear_smvm  in  1  sampled with accepted start; zeroes accumulators and saturation flags.
REQ-008 i_sign_smvm  in  1  weight sign, 1 = negative; sampled at start.
REQ-009 i_w_smvm  in  NUM_BIT  weight magnitude, unsigned; sampled at start.
REQ-010 i_x_smvm  in  DIM x NUM_BIT  activations, unsigned; held stable by the source from start until o_done.
REQ-011 o_busy_smvm  out  1  high in RUN and DONE.
REQ-012 o_done_smvm  out  1  one-cycle completion pulse.
REQ-013 o_acc_smvm  out  DIM x ACC_W  signed per-lane accumulators, registered.
REQ-014 o_sat_smvm  out  DIM  sticky per-lane saturation flags.

Function
REQ-015 FSM states are IDLE, RUN and DONE; the reset state is IDLE.
REQ-016 IDLE with i_start_smvm=1 shall latch w and sign, clear the phase counter t to 0, and clear the accumulators if i_clear_smvm=1.
REQ-017 From IDLE, a latched w of 0 shall go to DONE; a nonzero latched w shall go to RUN.
REQ-018 While not in IDLE, i_start_smvm and i_clear_smvm are ignored.
REQ-019 Stochastic stream: r_t is the NUM_BIT-bit bit-reverse of t, and sn_i is 1 when x_i > r_t (unsigned compare).
REQ-020 Each RUN cycle shall update every lane, adding +1 when sn_i XOR sign is 1 and -1 otherwise, then increment t.
REQ-021 RUN shall last exactly w cycles, then go to DONE; DONE shall last one cycle with o_done_smvm=1, then return to IDLE.
REQ-022 Latency: with start accepted at edge k and w>0, the final update occurs at edge k+w and o_done_smvm is high during the cycle after edge k+w.
REQ-023 Latency: with w=0, o_done_smvm is high during the cycle after edge k and the accumulators are unchanged apart from any clear.
REQ-024 Accumulators shall persist across runs unless cleared, so successive starts accumulate w_j*x products over a matrix row.
REQ-025 o_busy_smvm is asserted during RUN and DONE, and 0 in IDLE.
REQ-026 o_acc_smvm is stable in IDLE and valid when o_done_smvm is high.
REQ-027 A start accepted in the same cycle that DONE returns to IDLE is not possible; start is taken earliest in the first IDLE cycle.

Reset
REQ-028 Assertion of i_rst_n_smvm low shall immediately set: state IDLE, t=0, latched w=0, latched sign=0, o_acc_smvm=0, o_sat_smvm=0, o_done_smvm=0, o_busy_smvm=0.
REQ-029 Reset asserted mid-RUN shall abort the run with no completion pulse.
REQ-030 Reset release shall be synchronised by the integrator, and the first start is accepted on the first edge after release.

Configuration
REQ-031 Macro SMVM_SATURATE_EN selects the accumulator overflow behaviour.
REQ-032 Defined: a lane at +(2^(ACC_W-1))-1 receiving +1, or at -2^(ACC_W-1) receiving -1, shall hold its value and set o_sat_smvm[i] until cleared or reset.
REQ-033 Undefined: accumulators shall wrap modulo 2^ACC_W, and o_sat_smvm shall be constant 0.

Verification (DIM=4, NUM_BIT=8, ACC_W=16)
REQ-034 Start+clear with x=255, w=10, sign=0 shall give all lanes +10, o_done_smvm high 11 cycles after start, and o_busy_smvm high for 11 cycles.
REQ-035 x=0, w=10, sign=0 shall give -10; the same inputs with sign=1 shall give +10.
REQ-036 x=128, w=4, sign=0 (r=0,128,64,192) shall give 0; with w=3 it shall give +1.
REQ-037 Two runs without clear (x=255, w=5 then w=7, sign=1) shall give -12; w=0 shall give o_done_smvm 1 cycle after start with o_acc_smvm unchanged.
REQ-038 Preload to 32767 (x=255, runs of w=255) followed by one more +1 shall hold 32767 with o_sat_smvm=1 under SMVM_SATURATE_EN, and wrap to -32768 with o_sat_smvm=0 without it.
REQ-039 Reset pulsed at RUN cycle 3 shall zero all outputs immediately, produce no o_done_smvm, and the next start shall behave normally.
